// File: rtl/speed_ctrl_pkg.sv
// speed_ctrl_pkg: shared types and constants for the speed ramp controller
//   state_e      controller states IDLE..HALT
//   RNG_*        2-bit obstacle range codes
//   SPEED_W      speed/target width
//   MAX_SPEED_DEF default upper speed clamp
//   clamp_speed  limits a requested speed to a maximum
package speed_ctrl_pkg;

   localparam int SPEED_W       = 4;
   localparam int MAX_SPEED_DEF = 15;

   typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, HALT} state_e;

   localparam logic [1:0] RNG_NONE = 2'b00;
   localparam logic [1:0] RNG_FAR  = 2'b01;
   localparam logic [1:0] RNG_MID  = 2'b10;
   localparam logic [1:0] RNG_NEAR = 2'b11;

   function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] v,
                                                      input logic [SPEED_W-1:0] mx);
      return (v > mx) ? mx : v;
   endfunction

endpackage

// File: rtl/speed_ramp_ctrl_ramp_prescaler.sv
// ramp_prescaler: counts clocks while enabled and pulses step every RAMP_DIV-th clock
//   clk, rst  clock, asynchronous active-high reset
//   en        count enable (controller is ramping)
//   clr       restart the count from zero (controller changed state)
//   step      high in the cycle whose closing edge applies one speed step
module ramp_prescaler #(
   parameter int RAMP_DIV = 8,
   parameter int DIV_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(RAMP_DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : !en ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Step depends only on the registered count, so clr (derived from the
   // next state) never feeds back into the step decision.
   assign step = en && (cnt_q == LAST);

endmodule

// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: ramps speed toward a target, decodes range zones, halts on near obstacles
//   clk, rst   clock, asynchronous active-high reset
//   start      pulse: begin/resume motion toward target
//   stop       pulse: ramp down to 0, then idle
//   target     requested speed (clamped to MAX_SPEED)
//   range      00 none, 01 far, 10 mid, 11 near
//   speed      current speed (registered)
//   dist_0/1/2 near/mid/far zone lines, one cycle behind range
//   busy       ramping (ACCEL/DECEL)
//   at_target  cruising
// Build option SPEED_RAMP_SOFTSTOP_EN: near obstacle ramps down one step per
// clock through DECEL before HALT instead of dropping to 0 at once.
module speed_ramp_ctrl
   import speed_ctrl_pkg::*;
#(
   parameter int MAX_SPEED = MAX_SPEED_DEF,
   parameter int RAMP_DIV  = 8,
   parameter int DIV_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] target,
   input  logic [1:0] range,
   output logic [3:0] speed,
   output logic       dist_0,
   output logic       dist_1,
   output logic       dist_2,
   output logic       busy,
   output logic       at_target
);

   localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);
   localparam logic [SPEED_W-1:0] ONE   = SPEED_W'(1);

   state_e     state_q, state_d;
   logic [3:0] speed_q, speed_d, tgt_q, tgt_d, tgt_e;
   logic [2:0] dist_q, dist_d;
   logic       stop_req_q, stop_req_d, busy_q, busy_d, at_target_q, at_target_d;
   logic       near, step, ramp_en, ramp_clr;
`ifdef SPEED_RAMP_SOFTSTOP_EN
   logic       soft_q, soft_d;
`endif

   assign near     = range == RNG_NEAR;
   // A stop pulse acts as a zero target in its own cycle, so ramping logic
   // (including a step due that cycle) needs no separate stop path.
   assign tgt_e    = (stop || stop_req_q) ? '0 : tgt_q;
   assign ramp_en  = state_q == ACCEL || state_q == DECEL;
   assign ramp_clr = state_d != state_q;

   ramp_prescaler #(.RAMP_DIV(RAMP_DIV), .DIV_W(DIV_W)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (ramp_en),
      .clr  (ramp_clr),
      .step (step)
   );

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
`ifdef SPEED_RAMP_SOFTSTOP_EN
      soft_d  = soft_q;
      if (soft_q || near) begin
         state_d = (speed_q <= ONE) ? HALT : DECEL;
         speed_d = (speed_q == '0) ? '0 : speed_q - ONE;
         soft_d  = speed_q > ONE;
      end
`else
      if (near) begin
         state_d = HALT;
         speed_d = '0;
      end
`endif
      else if (state_q == HALT)
         state_d = stop ? DECEL : start ? ACCEL : HALT;
      else if (state_q == IDLE)
         state_d = (start && !stop && tgt_q != '0) ? ACCEL : IDLE;
      else if (state_q == CRUISE)
         state_d = (tgt_e > speed_q) ? ACCEL : (tgt_e < speed_q) ? DECEL : CRUISE;
      else if (state_q == ACCEL) begin
         if (tgt_e < speed_q)
            state_d = DECEL;
         else if (tgt_e == speed_q)
            state_d = (speed_q == '0) ? IDLE : CRUISE;
         else if (step) begin
            speed_d = speed_q + ONE;
            state_d = (speed_q + ONE == tgt_e) ? CRUISE : ACCEL;
         end
      end else begin
         if (speed_q == '0)
            state_d = IDLE;
         else if (tgt_e > speed_q)
            state_d = ACCEL;
         else if (tgt_e == speed_q)
            state_d = CRUISE;
         else if (step) begin
            speed_d = speed_q - ONE;
            state_d = (speed_q - ONE != tgt_e) ? DECEL : (tgt_e == '0) ? IDLE : CRUISE;
         end
      end
      stop_req_d  = (state_d == IDLE || state_d == HALT) ? 1'b0 :
                    (stop && state_q != IDLE) ? 1'b1 : stop_req_q;
      tgt_d       = stop_req_d ? '0 : clamp_speed(target, MAX_S);
      busy_d      = state_d == ACCEL || state_d == DECEL;
      at_target_d = state_d == CRUISE;
      dist_d      = {range == RNG_FAR, range == RNG_MID, range == RNG_NEAR};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         speed_q     <= '0;
         tgt_q       <= '0;
         stop_req_q  <= 1'b0;
         dist_q      <= '0;
         busy_q      <= 1'b0;
         at_target_q <= 1'b0;
`ifdef SPEED_RAMP_SOFTSTOP_EN
         soft_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         speed_q     <= speed_d;
         tgt_q       <= tgt_d;
         stop_req_q  <= stop_req_d;
         dist_q      <= dist_d;
         busy_q      <= busy_d;
         at_target_q <= at_target_d;
`ifdef SPEED_RAMP_SOFTSTOP_EN
         soft_q      <= soft_d;
`endif
      end
   end

   assign speed     = speed_q;
   assign dist_0    = dist_q[0];
   assign dist_1    = dist_q[1];
   assign dist_2    = dist_q[2];
   assign busy      = busy_q;
   assign at_target = at_target_q;

endmodule
